// File: rtl/mem_access_ctrl_pkg.sv
// Shared MEM-stage definitions: load-type encodings, controller state, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Package mem_pkg, imported by mem_access_ctrl and load_extender.
package mem_pkg;

   localparam int MEM_ADDR_W = 32;
   localparam int MEM_DATA_W = 32;
   localparam int MEM_BE_W   = MEM_DATA_W / 8;

   // Load type encodings as carried down the pipeline from decode.
   localparam logic [2:0] NOREGWRITE = 3'd0;
   localparam logic [2:0] LB         = 3'd1;
   localparam logic [2:0] LH         = 3'd2;
   localparam logic [2:0] LW         = 3'd3;
   localparam logic [2:0] LBU        = 3'd4;
   localparam logic [2:0] LHU        = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_access_ctrl_load_extender.sv
// Load extender: selects byte/half from a read word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: rdata (cache read word), byte_off (addr[1:0]), load_type (mem_pkg
// encoding), data (extended result; 0 for NOREGWRITE/unknown types).
module load_extender
   import mem_pkg::*;
(
   input  logic [MEM_DATA_W-1:0] rdata,
   input  logic [1:0]            byte_off,
   input  logic [2:0]            load_type,
   output logic [MEM_DATA_W-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{byte_off, 3'b000} +: 8];
      // Halfword uses addr[1] only, so a misaligned LH/LHU quietly rounds down.
      half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
      data     = '0;
      case (load_type)
         LB:      data = {{24{byte_sel[7]}}, byte_sel};
         LBU:     data = {24'h0, byte_sel};
         LH:      data = {{16{half_sel[15]}}, half_sel};
         LHU:     data = {16'h0, half_sel};
         LW:      data = rdata;
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-cache access controller with load extension and store alignment.
// Latency: 2 cycles minimum per memory access (request, DONE); 0 for non-memory ops.
// Backpressure: stall_mem holds the pipeline until mem_ack; stall_ext holds DONE.
//
// Ports: cache_read_en_MEM/cache_write_en_MEM/load_type_MEM/addr_MEM/store_data_MEM
// from the EX/MEM register; mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata form
// the req/ack cache port; load_data is the extended load result, stall_mem the hold.
// Optional: define MEM_PERF_CNT_EN to add perf_access_cnt/perf_stall_cnt outputs.
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              cache_read_en_MEM,
   input  logic [3:0]        cache_write_en_MEM,
   input  logic [2:0]        load_type_MEM,
   input  logic [ADDR_W-1:0] addr_MEM,
   input  logic [DATA_W-1:0] store_data_MEM,
   input  logic              stall_ext,
   output logic              mem_req,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] load_data,
   output logic              stall_mem
`ifdef MEM_PERF_CNT_EN
   ,
   output logic [31:0]       perf_access_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   mem_state_e        state;
   logic              access;
   logic              issue;
   logic              capture;
   logic [2:0]        ext_type;
   logic [DATA_W-1:0] ext_data;

   assign access = cache_read_en_MEM | (|cache_write_en_MEM);

   // Request is combinational so a single-cycle hit costs only the request cycle.
   // Gated by rst so nothing is presented to the cache while reset is held.
   assign issue   = ~rst & (((state == IDLE) & access) | (state == WAIT));
   assign capture = issue & mem_ack;

   assign mem_req   = issue;
   assign stall_mem = issue;
   assign mem_addr  = {addr_MEM[ADDR_W-1:2], 2'b00};
   assign mem_wdata = store_data_MEM << {addr_MEM[1:0], 3'b000};
   // A read with a nonzero mask is illegal; the read wins and no bytes are written.
   assign mem_we    = (issue & ~cache_read_en_MEM) ? cache_write_en_MEM : 4'b0000;

   // Stores (and NOREGWRITE) extend to zero, so the capture register reads 0.
   assign ext_type = cache_read_en_MEM ? load_type_MEM : NOREGWRITE;

   load_extender u_load_extender (
      .rdata     (mem_rdata),
      .byte_off  (addr_MEM[1:0]),
      .load_type (ext_type),
      .data      (ext_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         load_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  if (mem_ack) begin
                     load_data <= ext_data;
                     state     <= DONE;
                  end else begin
                     state     <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (mem_ack) begin
                  load_data <= ext_data;
                  state     <= DONE;
               end
            end
            DONE: begin
               // The same instruction sits in MEM while held; never re-issue it.
               if (!stall_ext) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_access_cnt <= '0;
         perf_stall_cnt  <= '0;
      end else begin
         if (capture && (perf_access_cnt != 32'hFFFF_FFFF))
            perf_access_cnt <= perf_access_cnt + 32'd1;
         if (stall_mem && (perf_stall_cnt != 32'hFFFF_FFFF))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule
